any1_memunit: RTL

- Load/store execution unit. Consumes a registered effective address plus operation info and performs the matching data-bus transaction(s).
- Performs byte-lane steering and sign/zero extension of load data.
- Splits accesses that straddle a 64-bit word boundary into two bus cycles.
- Sits between the address-generation stage and the 64-bit data bus. Returns one response per accepted request.

---
 rtl/any1_memunit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/any1_memunit.sv
// Load/store execution unit: steers byte lanes onto a 64-bit data bus, splits
// accesses that straddle a word boundary, and extends load data to 64 bits.
module any1_memunit #(
  parameter int AWID = 32,
  parameter int TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_sext_i,
  input  logic [AWID-1:0] req_ea_i,
  input  logic [63:0]     req_sdat_i,
  output logic            resp_valid_o,
  output logic [63:0]     resp_data_o,
  output logic            resp_err_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [7:0]      sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [63:0]     dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [63:0]     dat_i
);

  typedef enum logic [1:0] {IDLE, BUS1, BUS2, DONE} state_t;

  state_t state, state_nx;

  logic        store_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [2:0]  ofs_q;
  logic [7:0]  sel_hi_q;
  logic [63:0] wdat_hi_q;
  logic [63:0] lo_q;
  logic [63:0] hi_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic [15:0]  mask16;
  logic [15:0]  sel16;
  logic [127:0] wdat128;
  logic [63:0]  rd;
  logic [63:0]  ld_data;
  logic         tmo_hit;
  logic         bus_err;

  assign req_ready_o = (state == IDLE);
  assign tmo_hit     = (TMO != 0) && (cnt_q == 16'(TMO));
  // err_i wins over ack_i; an expired wait is handled exactly like a bus error.
  assign bus_err     = err_i || tmo_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mask16 = 16'h0001;
    case (req_size_i)
      2'b00: mask16 = 16'h0001;
      2'b01: mask16 = 16'h0003;
      2'b10: mask16 = 16'h000f;
      2'b11: mask16 = 16'h00ff;
      default: mask16 = 16'h0001;
    endcase
    sel16   = mask16 << req_ea_i[2:0];
    wdat128 = {64'd0, req_sdat_i} << {req_ea_i[2:0], 3'b000};
  end

  // Right-justify the addressed bytes out of the (possibly two-word) read data.
  always_comb begin
    rd      = 64'({hi_q, lo_q} >> {ofs_q, 3'b000});
    ld_data = rd;
    case (size_q)
      2'b00: ld_data = {{56{sext_q & rd[7]}},  rd[7:0]};
      2'b01: ld_data = {{48{sext_q & rd[15]}}, rd[15:0]};
      2'b10: ld_data = {{32{sext_q & rd[31]}}, rd[31:0]};
      2'b11: ld_data = rd;
      default: ld_data = rd;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid_i) state_nx = BUS1;
      BUS1: begin
        if (bus_err)    state_nx = DONE;
        else if (ack_i) state_nx = (sel_hi_q != 8'd0) ? BUS2 : DONE;
      end
      BUS2: if (bus_err || ack_i) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q      <= 1'b0;
      sext_q       <= 1'b0;
      size_q       <= 2'd0;
      ofs_q        <= 3'd0;
      sel_hi_q     <= 8'd0;
      wdat_hi_q    <= 64'd0;
      lo_q         <= 64'd0;
      hi_q         <= 64'd0;
      err_q        <= 1'b0;
      cnt_q        <= 16'd0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      sel_o        <= 8'd0;
      adr_o        <= '0;
      dat_o        <= 64'd0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_data_o  <= 64'd0;
    end else begin
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          store_q   <= req_store_i;
          sext_q    <= req_sext_i;
          size_q    <= req_size_i;
          ofs_q     <= req_ea_i[2:0];
          sel_hi_q  <= sel16[15:8];
          wdat_hi_q <= wdat128[127:64];
          err_q     <= 1'b0;
          cnt_q     <= 16'd0;
          cyc_o     <= 1'b1;
          stb_o     <= 1'b1;
          we_o      <= req_store_i;
          adr_o     <= {req_ea_i[AWID-1:3], 3'b000};
          sel_o     <= sel16[7:0];
          dat_o     <= wdat128[63:0];
        end
        BUS1: begin
          if (bus_err) begin
            {cyc_o, stb_o, we_o} <= 3'b000;
            err_q                <= 1'b1;
          end else if (ack_i) begin
            lo_q  <= dat_i;
            cnt_q <= 16'd0;
            if (sel_hi_q != 8'd0) begin
              adr_o <= adr_o + AWID'(8);
              sel_o <= sel_hi_q;
              dat_o <= wdat_hi_q;
            end else begin
              {cyc_o, stb_o, we_o} <= 3'b000;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        BUS2: begin
          if (bus_err) begin
            {cyc_o, stb_o, we_o} <= 3'b000;
            err_q                <= 1'b1;
          end else if (ack_i) begin
            hi_q                 <= dat_i;
            {cyc_o, stb_o, we_o} <= 3'b000;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          resp_valid_o <= 1'b1;
          resp_err_o   <= err_q;
          resp_data_o  <= store_q ? 64'd0 : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule
